stage_sequencer: RTL and testbench

- Multi-cycle control sequencer for the picoMips core.
- Owns the program address and the per-instruction stage count, and produces the execute and writeback strobes that gate accumulator and register writes.
- Stalls on WAIT instructions until a full press/release of the Handshake switch.
- Sits between program memory and the control decoder; replaces free-running stage bits taken from the PC.

---
 rtl/stage_sequencer.sv | 170 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
//
// Multi-cycle control sequencer for the picoMips core. It owns the program
// address and the per-instruction stage count, and it produces the execute
// and writeback strobes that gate the accumulator and register-file writes.
// A WAIT instruction stalls the core until the Handshake switch has been
// pressed and then released.
//
// Ports:
//   clk_i            system clock; all state changes on the rising edge
//   rst_i            asynchronous active-high reset
//   handshake_i      raw switch level, asynchronous to clk_i
//   is_wait_i        decoded instruction needs a handshake (used in DECODE)
//   is_branch_i      decoded instruction is a branch (used in WB)
//   branch_taken_i   branch condition is true (used in WB)
//   branch_target_i  absolute branch destination (used in WB)
//   addr_o           program memory address
//   stage_o          0=FETCH 1=DECODE 2=EXEC 3=WB (stays 1 while waiting)
//   exec_strobe_o    one-cycle pulse during EXEC
//   write_strobe_o   one-cycle pulse during WB
//   waiting_o        high while stalled on the handshake
//   retired_o        count of completed instructions, wraps
// ---------------------------------------------------------------------------
module stage_sequencer #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              handshake_i,
    input  logic              is_wait_i,
    input  logic              is_branch_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [1:0]        stage_o,
    output logic              exec_strobe_o,
    output logic              write_strobe_o,
    output logic              waiting_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_EXEC    = 3'd4,
        ST_WB      = 3'd5
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [CNT_W-1:0]    retired_q;
    logic [CNT_W-1:0]    retired_d;
    logic [1:0]          stage_q;
    logic                exec_q;
    logic                write_q;
    logic                waiting_q;
    logic                hs_meta_q;
    logic                hs_q;

    // Externally visible stage number; both wait states report DECODE.
    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] v;
        case (s)
            ST_FETCH:   v = 2'd0;
            ST_DECODE:  v = 2'd1;
            ST_WAIT_HI: v = 2'd1;
            ST_WAIT_LO: v = 2'd1;
            ST_EXEC:    v = 2'd2;
            ST_WB:      v = 2'd3;
            default:    v = 2'd0;
        endcase
        return v;
    endfunction

    // Two-flop synchroniser for the asynchronous handshake switch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_meta_q <= 1'b0;
            hs_q      <= 1'b0;
        end else begin
            hs_meta_q <= handshake_i;
            hs_q      <= hs_meta_q;
        end
    end

    // Next-state, next-address and retire-count logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_wait_i) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_WAIT_HI: begin
                if (hs_q) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                // Requiring the release means one press frees exactly one WAIT.
                if (!hs_q) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d   = ST_FETCH;
                retired_d = retired_q + CNT_W'(1);
                if (is_branch_i && branch_taken_i) begin
                    addr_d = branch_target_i;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so they
    // are registered yet line up with the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            addr_q    <= {ADDR_W{1'b0}};
            retired_q <= {CNT_W{1'b0}};
            stage_q   <= 2'd0;
            exec_q    <= 1'b0;
            write_q   <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            retired_q <= retired_d;
            stage_q   <= stage_of(state_d);
            exec_q    <= (state_d == ST_EXEC);
            write_q   <= (state_d == ST_WB);
            waiting_q <= (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
        end
    end

    assign addr_o         = addr_q;
    assign retired_o      = retired_q;
    assign stage_o        = stage_q;
    assign exec_strobe_o  = exec_q;
    assign write_strobe_o = write_q;
    assign waiting_o      = waiting_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus a randomized phase,
// every cycle compared against a behavioural model of the instruction cycle.
module tb_stage_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       handshake_i;
    logic       is_wait_i;
    logic       is_branch_i;
    logic       branch_taken_i;
    logic [4:0] branch_target_i;
    logic [4:0] addr_o;
    logic [1:0] stage_o;
    logic       exec_strobe_o;
    logic       write_strobe_o;
    logic       waiting_o;
    logic [7:0] retired_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_exec_seen  = 0;
    int n_write_seen = 0;

    // Model: stage number 0..3, stall phase (0 none, 1 needs press,
    // 2 needs release), address/count as integers, and the synchroniser
    // treated as a two-deep delay line of past switch levels.
    int m_stage;
    int m_stall;
    int m_addr;
    int m_ret;
    logic m_dly1;
    logic m_dly2;

    stage_sequencer #(.ADDR_W(5), .CNT_W(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .handshake_i    (handshake_i),
        .is_wait_i      (is_wait_i),
        .is_branch_i    (is_branch_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .addr_o         (addr_o),
        .stage_o        (stage_o),
        .exec_strobe_o  (exec_strobe_o),
        .write_strobe_o (write_strobe_o),
        .waiting_o      (waiting_o),
        .retired_o      (retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_stall = 0; m_addr = 0; m_ret = 0;
        m_dly1 = 1'b0; m_dly2 = 1'b0;
    endtask

    task automatic model_edge();
        logic hs_seen;
        hs_seen = m_dly2;
        m_dly2  = m_dly1;
        m_dly1  = handshake_i;
        if (m_stall == 1) begin
            if (hs_seen) m_stall = 2;
        end else if (m_stall == 2) begin
            if (!hs_seen) begin
                m_stall = 0;
                m_stage = 2;
            end
        end else if (m_stage == 1 && is_wait_i) begin
            m_stall = 1;
        end else begin
            if (m_stage == 3) begin
                if (is_branch_i && branch_taken_i) m_addr = int'(branch_target_i);
                else m_addr = (m_addr + 1) % 32;
                m_ret = (m_ret + 1) % 256;
            end
            m_stage = (m_stage + 1) % 4;
        end
    endtask

    task automatic check_all();
        chk("addr",    32'(addr_o),         32'(m_addr));
        chk("stage",   32'(stage_o),        32'(m_stage));
        chk("exec",    32'(exec_strobe_o),  32'(m_stall == 0 && m_stage == 2));
        chk("write",   32'(write_strobe_o), 32'(m_stall == 0 && m_stage == 3));
        chk("waiting", 32'(waiting_o),      32'(m_stall != 0));
        chk("retired", 32'(retired_o),      32'(m_ret));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
        if (exec_strobe_o)  n_exec_seen++;
        if (write_strobe_o) n_write_seen++;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One non-WAIT instruction starting at FETCH.
    task automatic run_instr(input logic br, input logic tk, input logic [4:0] tgt);
        is_wait_i = 1'b0; is_branch_i = br; branch_taken_i = tk; branch_target_i = tgt;
        repeat (4) tick();
        is_branch_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    // Count edges from now until the first ExecStrobe (bounded).
    task automatic exec_latency(input string tag, input int exp);
        int cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            cnt++;
            if (exec_strobe_o) break;
        end
        chk(tag, 32'(cnt), 32'(exp));
    endtask

    // Drive the model back to FETCH, pressing/releasing as needed (bounded).
    task automatic goto_fetch();
        is_wait_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_stage == 0 && m_stall == 0) break;
            handshake_i = (m_stall == 1);
            tick();
        end
        handshake_i = 1'b0;
        chk("goto_fetch", 32'(stage_o), 32'd0);
    endtask

    initial begin
        int hold;
        rst_i = 1'b0; handshake_i = 1'b0; is_wait_i = 1'b0;
        is_branch_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 5'd0;
        #2;

        // Reset release and 3 plain instructions.
        apply_reset();
        n_exec_seen = 0; n_write_seen = 0;
        repeat (12) tick();
        chk("intro_retired", 32'(retired_o), 32'd3);
        chk("intro_addr",    32'(addr_o),    32'd3);
        chk("intro_execs",   32'(n_exec_seen),  32'd3);
        chk("intro_writes",  32'(n_write_seen), 32'd3);

        // Branches.
        run_instr(1'b1, 1'b1, 5'd9);
        chk("br_taken", 32'(addr_o), 32'd9);
        run_instr(1'b1, 1'b1, 5'd4);
        run_instr(1'b1, 1'b0, 5'd20);
        chk("br_not_taken", 32'(addr_o), 32'd5);
        run_instr(1'b0, 1'b1, 5'd17);
        chk("nobranch_taken", 32'(addr_o), 32'd6);

        // WAIT: low 10, high 5, then release.
        is_wait_i = 1'b1; handshake_i = 1'b0;
        tick(); tick();
        is_wait_i = 1'b0;
        chk("wait_entered", 32'(waiting_o), 32'd1);
        repeat (10) tick();
        handshake_i = 1'b1;
        repeat (5) tick();
        chk("wait_press_stage", 32'(stage_o), 32'd1);
        handshake_i = 1'b0;
        exec_latency("wait_exec_latency", 3);
        tick(); tick();

        // Switch already high when entering the wait.
        is_wait_i = 1'b1; handshake_i = 1'b1;
        tick(); tick(); tick();
        is_wait_i = 1'b0;
        repeat (5) tick();
        chk("held_high_stalled", 32'(waiting_o), 32'd1);
        handshake_i = 1'b0;
        exec_latency("held_release_latency", 3);
        tick(); tick();
        // Second WAIT needs a fresh press.
        is_wait_i = 1'b1;
        tick(); tick();
        is_wait_i = 1'b0;
        repeat (6) tick();
        chk("second_wait_needs_press", 32'(waiting_o), 32'd1);
        handshake_i = 1'b1;
        repeat (3) tick();
        handshake_i = 1'b0;
        exec_latency("second_wait_latency", 3);
        goto_fetch();

        // Randomized phase.
        hold = 0;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin
                handshake_i = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 8));
            end else begin
                hold--;
            end
            is_wait_i       = ($urandom_range(0, 3) == 0);
            is_branch_i     = 1'($urandom_range(0, 1));
            branch_taken_i  = 1'($urandom_range(0, 1));
            branch_target_i = 5'($urandom_range(0, 31));
            tick();
        end
        is_branch_i = 1'b0; branch_taken_i = 1'b0;
        goto_fetch();

        // Address wrap 31 -> 0.
        apply_reset();
        for (int i = 0; i < 31; i++) run_instr(1'b0, 1'b0, 5'd0);
        chk("addr_31", 32'(addr_o), 32'd31);
        run_instr(1'b0, 1'b0, 5'd0);
        chk("addr_wrap", 32'(addr_o), 32'd0);
        chk("ret_after_wrap", 32'(retired_o), 32'd32);

        // Async reset mid-WAIT_LO with Addr=7, Retired=20.
        apply_reset();
        for (int i = 0; i < 19; i++) run_instr(1'b0, 1'b0, 5'd0);
        run_instr(1'b1, 1'b1, 5'd7);
        is_wait_i = 1'b1; handshake_i = 1'b0;
        tick(); tick();
        is_wait_i = 1'b0; handshake_i = 1'b1;
        repeat (3) tick();
        chk("pre_rst_addr",    32'(addr_o),    32'd7);
        chk("pre_rst_retired", 32'(retired_o), 32'd20);
        chk("pre_rst_waiting", 32'(waiting_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_addr",    32'(addr_o),         32'd0);
        chk("async_rst_retired", 32'(retired_o),      32'd0);
        chk("async_rst_waiting", 32'(waiting_o),      32'd0);
        chk("async_rst_stage",   32'(stage_o),        32'd0);
        chk("async_rst_strobes", 32'({exec_strobe_o, write_strobe_o}), 32'd0);
        handshake_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        run_instr(1'b0, 1'b0, 5'd0);
        chk("restart_addr", 32'(addr_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
